roce_stack_addr_translator: RTL and testbench
=============================================

ROCE_STACK_ADDR_TRANSLATOR -- requirements
Module: roce_stack_addr_translator

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 16, number of translation entries (2..64).
REQ-002 SHALL have localparam IDX_W, default $clog2(NUM_ENTRIES), entry index width.
REQ-003 clk_i  input  1  single clock; all logic on rising edge.
REQ-004 aresetn_i  input  1  reset, asynchronous assertion, active-low.
REQ-005 s_cfg_valid_i  input  1  entry-write request.
REQ-006 s_cfg_ready_o  output  1  entry-write accepted when high with valid.
REQ-007 s_cfg_idx_i  input  IDX_W  entry index to write.
REQ-008 s_cfg_en_i  input  1  entry valid bit to store.
REQ-009 s_cfg_vaddr_i  input  64  entry base virtual address.
REQ-010 s_cfg_paddr_i  input  64  entry base physical address.
REQ-011 s_cfg_buflen_i  input  48  entry buffer length in bytes.
REQ-012 s_cfg_accessdesc_i  input  4  entry access descriptor; 4'h0 is reserved to mean "no access".
REQ-013 req_addr_valid_i  input  1  lookup request from the request handler.
REQ-014 req_addr_ready_o  output  1  lookup accepted.
REQ-015 req_addr_vaddr_i  input  64  virtual address to translate.
REQ-016 resp_addr_valid_o  output  1  lookup result valid.
REQ-017 resp_addr_ready_i  input  1  result consumed.
REQ-018 resp_addr_data_o  output  116  {accessdesc[115:112], buflen[111:64], paddr[63:0]}.
REQ-019 miss_cnt_o  output  32  count of lookups that missed; saturates at 32'hFFFF_FFFF.

Function
REQ-020 FSM states: AT_IDLE, AT_SEARCH, AT_RESP.
REQ-021 AT_IDLE: req_addr_ready_o=1 and s_cfg_ready_o=1; on req handshake, capture vaddr, set idx=0, go to AT_SEARCH.
REQ-022 In all other states, req_addr_ready_o=0 and s_cfg_ready_o=0, so the table cannot change mid-lookup.
REQ-023 A config handshake writes all fields of entry s_cfg_idx_i at that clock edge.
REQ-024 Config write and req handshake in the same cycle: both are accepted, and the search sees the newly written entry.
REQ-025 AT_SEARCH evaluates one entry per cycle, starting at index 0 and ascending.
REQ-026 Entry k hits iff: valid, vaddr >= base_vaddr (64-bit unsigned), and offset = vaddr - base_vaddr < {16'b0, buflen}; buflen=0 never hits.
REQ-027 The first (lowest-index) hit ends the search; latch paddr = entry.paddr + offset (64-bit, wraps mod 2^64), buflen = entry.buflen - offset[47:0], accessdesc = entry.accessdesc; go to AT_RESP.
REQ-028 No hit at idx=NUM_ENTRIES-1: latch data=116'h0, increment miss_cnt_o (saturating), go to AT_RESP.
REQ-029 Latency: req handshake at cycle T and hit at entry k gives resp_addr_valid_o high at T+2+k; a miss gives resp_addr_valid_o high at T+1+NUM_ENTRIES.
REQ-030 AT_RESP: resp_addr_valid_o=1; resp_addr_data_o is registered and stable until the handshake; on resp_addr_ready_i go to AT_IDLE.
REQ-031 Exactly one response per accepted request; the next request is accepted no earlier than the cycle after the response handshake.
REQ-032 resp_addr_data_o SHALL be 0 whenever resp_addr_valid_o=0.

Reset
REQ-033 Asserting aresetn_i low asynchronously clears, at any time, including mid-search or mid-response:
- all entry valid bits and entry fields to 0;
- state to AT_IDLE;
- idx to 0, miss_cnt_o to 0, latched response to 0.
REQ-034 Output values during and after reset: resp_addr_valid_o=0, resp_addr_data_o=0, miss_cnt_o=0, req_addr_ready_o=1, s_cfg_ready_o=1. An in-flight lookup is dropped and no response is issued.

Structure
REQ-035 Package roce_stack_pkg SHALL hold at_entry_t (valid, vaddr, paddr, buflen, accessdesc), at_resp_t (packed 116-bit layout of REQ-018), and the FSM enum.
REQ-036 Sub-module roce_stack_at_entry_match SHALL be purely combinational: at_entry_t plus vaddr in, hit/offset out.
REQ-037 Entry storage SHALL be flops (an array of at_entry_t), not a RAM macro.

Verification
REQ-038 Entry 0 = {en=1, vaddr=0x1000, paddr=0x8000_0000, buflen=0x2000, ad=4'h3}; lookup 0x1800 -> valid at T+2, data = {4'h3, 48'h1800, 64'h8000_0800}.
REQ-039 Same entry only at index 5; lookup 0x2FFF -> valid at T+7, paddr 0x8000_1FFF, buflen 1. Lookup 0x3000 -> miss, data 0, valid at T+17, miss_cnt_o=1.
REQ-040 Entries 2 and 4 overlap, both covering 0x1000; lookup 0x1000 -> returns entry 2's fields.
REQ-041 Hold resp_addr_ready_i=0 for 10 cycles -> valid and data stable, req_addr_ready_o=0 and s_cfg_ready_o=0 throughout; pulse ready -> IDLE on the next cycle.
REQ-042 Same-cycle config write enabling entry 0 plus a lookup hitting it -> hit at T+2. Then assert aresetn_i low during AT_SEARCH -> no response, miss_cnt_o=0, all entries invalid (a re-lookup misses).

Source files
------------

// File: rtl/roce_stack_pkg.sv
// Shared types for the RoCE address translator: table entry, packed lookup
// response, FSM encoding and a saturating counter helper.
package roce_stack_pkg;

    localparam int AT_ADDR_W = 64;
    localparam int AT_LEN_W  = 48;
    localparam int AT_AD_W   = 4;
    localparam int AT_RESP_W = AT_AD_W + AT_LEN_W + AT_ADDR_W;

    typedef struct packed {
        logic                 valid;
        logic [AT_ADDR_W-1:0] vaddr;
        logic [AT_ADDR_W-1:0] paddr;
        logic [AT_LEN_W-1:0]  buflen;
        logic [AT_AD_W-1:0]   accessdesc;
    } at_entry_t;

    typedef struct packed {
        logic [AT_AD_W-1:0]   accessdesc;
        logic [AT_LEN_W-1:0]  buflen;
        logic [AT_ADDR_W-1:0] paddr;
    } at_resp_t;

    typedef enum logic [1:0] {
        AT_IDLE   = 2'd0,
        AT_SEARCH = 2'd1,
        AT_RESP   = 2'd2
    } at_state_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/roce_stack_at_entry_match.sv
// Combinational hit test of one translation entry against a virtual address.
module roce_stack_at_entry_match
    import roce_stack_pkg::*;
(
    input  at_entry_t              entry,
    input  logic [AT_ADDR_W-1:0]   vaddr,
    output logic                   hit,
    output logic [AT_ADDR_W-1:0]   offset
);

    assign offset = vaddr - entry.vaddr;

    // A zero-length buffer can never satisfy offset < buflen, so it never hits.
    assign hit = entry.valid
              && (vaddr >= entry.vaddr)
              && (offset < {16'h0, entry.buflen});

endmodule

// File: rtl/roce_stack_addr_translator.sv
// Virtual-to-physical address translator: a flop-based entry table searched
// one entry per cycle, lowest index first, with a registered response.
module roce_stack_addr_translator
    import roce_stack_pkg::*;
#(
    parameter  int NUM_ENTRIES = 16,
    localparam int IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic                 clk_i,
    input  logic                 aresetn_i,
    input  logic                 s_cfg_valid_i,
    output logic                 s_cfg_ready_o,
    input  logic [IDX_W-1:0]     s_cfg_idx_i,
    input  logic                 s_cfg_en_i,
    input  logic [63:0]          s_cfg_vaddr_i,
    input  logic [63:0]          s_cfg_paddr_i,
    input  logic [47:0]          s_cfg_buflen_i,
    input  logic [3:0]           s_cfg_accessdesc_i,
    input  logic                 req_addr_valid_i,
    output logic                 req_addr_ready_o,
    input  logic [63:0]          req_addr_vaddr_i,
    output logic                 resp_addr_valid_o,
    input  logic                 resp_addr_ready_i,
    output logic [115:0]         resp_addr_data_o,
    output logic [31:0]          miss_cnt_o
);

    at_state_t             state_reg, state_next;
    at_entry_t             entry_tbl_reg [NUM_ENTRIES];
    at_entry_t             cfg_entry;
    at_entry_t             cur_entry;
    at_resp_t              resp_reg, hit_resp;
    logic [63:0]           vaddr_reg;
    logic [IDX_W-1:0]      idx_reg;
    logic [31:0]           miss_cnt_reg;
    logic [NUM_ENTRIES-1:0] wr_sel;
    logic                  cfg_fire, req_fire, last_idx;
    logic                  match_hit;
    logic [63:0]           match_offset;

    assign cfg_fire = s_cfg_valid_i && s_cfg_ready_o;
    assign req_fire = req_addr_valid_i && req_addr_ready_o;
    assign last_idx = (idx_reg == IDX_W'(NUM_ENTRIES - 1));

    assign cfg_entry = '{valid:      s_cfg_en_i,
                         vaddr:      s_cfg_vaddr_i,
                         paddr:      s_cfg_paddr_i,
                         buflen:     s_cfg_buflen_i,
                         accessdesc: s_cfg_accessdesc_i};

    generate
        for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_wr_sel
            assign wr_sel[gi] = cfg_fire && (s_cfg_idx_i == IDX_W'(gi));
        end
    endgenerate

    // Writes are only accepted in AT_IDLE, so the table is frozen during a search.
    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                entry_tbl_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (wr_sel[i]) begin
                    entry_tbl_reg[i] <= cfg_entry;
                end
            end
        end
    end

    assign cur_entry = entry_tbl_reg[idx_reg];

    roce_stack_at_entry_match u_match (
        .entry  (cur_entry),
        .vaddr  (vaddr_reg),
        .hit    (match_hit),
        .offset (match_offset)
    );

    assign hit_resp = '{accessdesc: cur_entry.accessdesc,
                        buflen:     cur_entry.buflen - match_offset[47:0],
                        paddr:      cur_entry.paddr + match_offset};

    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            state_reg <= AT_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            AT_IDLE:   if (req_fire) state_next = AT_SEARCH;
            AT_SEARCH: if (match_hit || last_idx) state_next = AT_RESP;
            AT_RESP:   if (resp_addr_ready_i) state_next = AT_IDLE;
            default:   state_next = AT_IDLE;
        endcase
    end

    always_comb begin
        req_addr_ready_o  = (state_reg == AT_IDLE);
        s_cfg_ready_o     = (state_reg == AT_IDLE);
        resp_addr_valid_o = (state_reg == AT_RESP);
    end

    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            vaddr_reg    <= '0;
            idx_reg      <= '0;
            resp_reg     <= '0;
            miss_cnt_reg <= '0;
        end else begin
            case (state_reg)
                AT_IDLE: begin
                    if (req_fire) begin
                        vaddr_reg <= req_addr_vaddr_i;
                        idx_reg   <= '0;
                    end
                end
                AT_SEARCH: begin
                    if (match_hit) begin
                        resp_reg <= hit_resp;
                    end else if (last_idx) begin
                        resp_reg     <= '0;
                        miss_cnt_reg <= sat_inc32(miss_cnt_reg);
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Latched data is masked outside AT_RESP so the bus reads zero when idle.
    assign resp_addr_data_o = resp_addr_valid_o ? resp_reg : '0;
    assign miss_cnt_o       = miss_cnt_reg;

endmodule

// File: tb/tb_roce_stack_addr_translator.sv
// Randomized scoreboard bench for roce_stack_addr_translator against an
// array-based translation model.
module tb_roce_stack_addr_translator;

    localparam int NE = 16;

    typedef struct {
        logic [115:0] data;
        int           t;
        logic [31:0]  miss;
    } exp_t;

    logic          clk_i = 1'b0;
    logic          aresetn_i = 1'b0;
    logic          s_cfg_valid_i = 1'b0;
    logic          s_cfg_ready_o;
    logic [3:0]    s_cfg_idx_i = '0;
    logic          s_cfg_en_i = 1'b0;
    logic [63:0]   s_cfg_vaddr_i = '0;
    logic [63:0]   s_cfg_paddr_i = '0;
    logic [47:0]   s_cfg_buflen_i = '0;
    logic [3:0]    s_cfg_accessdesc_i = '0;
    logic          req_addr_valid_i = 1'b0;
    logic          req_addr_ready_o;
    logic [63:0]   req_addr_vaddr_i = '0;
    logic          resp_addr_valid_o;
    logic          resp_addr_ready_i = 1'b0;
    logic [115:0]  resp_addr_data_o;
    logic [31:0]   miss_cnt_o;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    int stall_left = 0;
    bit in_resp = 0;
    bit expect_idle = 0;
    logic [115:0] held_data;
    exp_t exp_q[$];

    // Reference table
    logic        m_en  [NE];
    logic [63:0] m_va  [NE];
    logic [63:0] m_pa  [NE];
    logic [47:0] m_len [NE];
    logic [3:0]  m_ad  [NE];
    logic [31:0] m_miss;

    roce_stack_addr_translator #(.NUM_ENTRIES(NE)) dut (
        .clk_i              (clk_i),
        .aresetn_i          (aresetn_i),
        .s_cfg_valid_i      (s_cfg_valid_i),
        .s_cfg_ready_o      (s_cfg_ready_o),
        .s_cfg_idx_i        (s_cfg_idx_i),
        .s_cfg_en_i         (s_cfg_en_i),
        .s_cfg_vaddr_i      (s_cfg_vaddr_i),
        .s_cfg_paddr_i      (s_cfg_paddr_i),
        .s_cfg_buflen_i     (s_cfg_buflen_i),
        .s_cfg_accessdesc_i (s_cfg_accessdesc_i),
        .req_addr_valid_i   (req_addr_valid_i),
        .req_addr_ready_o   (req_addr_ready_o),
        .req_addr_vaddr_i   (req_addr_vaddr_i),
        .resp_addr_valid_o  (resp_addr_valid_o),
        .resp_addr_ready_i  (resp_addr_ready_i),
        .resp_addr_data_o   (resp_addr_data_o),
        .miss_cnt_o         (miss_cnt_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) edge_cnt <= edge_cnt + 1;

    task automatic finish_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    function automatic void model_clear();
        for (int i = 0; i < NE; i++) begin
            m_en[i] = 1'b0; m_va[i] = '0; m_pa[i] = '0; m_len[i] = '0; m_ad[i] = '0;
        end
        m_miss = '0;
    endfunction

    // First entry (lowest index) whose [base, base+len) window holds va.
    function automatic void model_lookup(input logic [63:0] va, output logic [115:0] d, output int k);
        logic [63:0] off;
        d = '0;
        k = -1;
        for (int i = 0; i < NE; i++) begin
            if (m_en[i] && va >= m_va[i] && (va - m_va[i]) < {16'h0, m_len[i]}) begin
                off = va - m_va[i];
                d = {m_ad[i], m_len[i] - off[47:0], m_pa[i] + off};
                k = i;
                break;
            end
        end
    endfunction

    function automatic void push_expect(input logic [63:0] va);
        exp_t e;
        int k;
        model_lookup(va, e.data, k);
        if (k < 0) begin
            if (m_miss != 32'hFFFF_FFFF) m_miss = m_miss + 1;
            e.t = edge_cnt + 1 + NE;
        end else begin
            e.t = edge_cnt + 2 + k;
        end
        e.miss = m_miss;
        exp_q.push_back(e);
    endfunction

    task automatic wait_idle();
        int n = 0;
        @(negedge clk_i);
        while (!(exp_q.size() == 0 && req_addr_ready_o && s_cfg_ready_o)) begin
            n++;
            if (n > 300) begin
                checks++; errors++;
                $display("FAIL wait_idle timeout: ready=%0b queue=%0d required idle", req_addr_ready_o, exp_q.size());
                finish_run();
            end
            @(negedge clk_i);
        end
    endtask

    task automatic cfg_and_lookup(input bit do_cfg, input int idx, input bit en, input logic [63:0] va,
                                  input logic [63:0] pa, input logic [47:0] len, input logic [3:0] ad,
                                  input bit do_lk, input logic [63:0] lk_va);
        wait_idle();
        if (do_cfg) begin
            s_cfg_valid_i = 1'b1; s_cfg_idx_i = 4'(idx); s_cfg_en_i = en;
            s_cfg_vaddr_i = va; s_cfg_paddr_i = pa; s_cfg_buflen_i = len; s_cfg_accessdesc_i = ad;
            m_en[idx] = en; m_va[idx] = va; m_pa[idx] = pa; m_len[idx] = len; m_ad[idx] = ad;
        end
        if (do_lk) begin
            req_addr_valid_i = 1'b1; req_addr_vaddr_i = lk_va;
            push_expect(lk_va);
        end
        @(negedge clk_i);
        s_cfg_valid_i = 1'b0;
        req_addr_valid_i = 1'b0;
    endtask

    task automatic lookup(input logic [63:0] va);
        cfg_and_lookup(0, 0, 0, '0, '0, '0, '0, 1, va);
    endtask

    task automatic cfg(input int idx, input bit en, input logic [63:0] va, input logic [63:0] pa,
                       input logic [47:0] len, input logic [3:0] ad);
        cfg_and_lookup(1, idx, en, va, pa, len, ad, 0, '0);
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (resp_addr_valid_o !== 1'b0 || resp_addr_data_o !== '0 || miss_cnt_o !== '0 ||
            req_addr_ready_o !== 1'b1 || s_cfg_ready_o !== 1'b1)
            begin
                errors++;
                $display("FAIL %s: valid=%0b data=%h miss=%0d rdy=%0b cfg_rdy=%0b required 0/0/0/1/1",
                         tag, resp_addr_valid_o, resp_addr_data_o, miss_cnt_o, req_addr_ready_o, s_cfg_ready_o);
            end
    endtask

    // Monitor / scoreboard: samples on the falling edge, drives resp ready.
    always @(negedge clk_i) begin
        if (expect_idle) begin
            checks++;
            if (resp_addr_valid_o || !req_addr_ready_o || !s_cfg_ready_o) begin
                errors++;
                $display("FAIL idle_after_hs: valid=%0b rdy=%0b cfg_rdy=%0b required 0/1/1",
                         resp_addr_valid_o, req_addr_ready_o, s_cfg_ready_o);
            end
            expect_idle = 0;
        end
        if (resp_addr_valid_o) begin
            checks++;
            if (!in_resp) begin
                in_resp = 1;
                held_data = resp_addr_data_o;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_resp: data=%h with no request outstanding", resp_addr_data_o);
                end else if (edge_cnt != exp_q[0].t) begin
                    errors++;
                    $display("FAIL latency: valid at cycle %0d required %0d", edge_cnt, exp_q[0].t);
                end
            end else if (resp_addr_data_o !== held_data) begin
                errors++;
                $display("FAIL data_stable: data=%h required %h", resp_addr_data_o, held_data);
            end
            checks++;
            if (req_addr_ready_o || s_cfg_ready_o) begin
                errors++;
                $display("FAIL busy_ready: rdy=%0b cfg_rdy=%0b required 0/0", req_addr_ready_o, s_cfg_ready_o);
            end
            if (stall_left > 0) begin
                resp_addr_ready_i = 1'b0;
                stall_left--;
            end else begin
                resp_addr_ready_i = ($urandom_range(0, 2) != 0);
            end
            if (resp_addr_ready_i) begin
                if (exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checks++;
                    if (resp_addr_data_o !== e.data) begin
                        errors++;
                        $display("FAIL resp_data: data=%h required %h", resp_addr_data_o, e.data);
                    end
                    checks++;
                    if (miss_cnt_o !== e.miss) begin
                        errors++;
                        $display("FAIL miss_cnt: miss=%0d required %0d", miss_cnt_o, e.miss);
                    end
                    $display("resp data=%h miss=%0d cycle=%0d", resp_addr_data_o, miss_cnt_o, edge_cnt);
                end
                in_resp = 0;
                expect_idle = 1;
            end
        end else begin
            resp_addr_ready_i = $urandom_range(0, 1);
            checks++;
            if (resp_addr_data_o !== '0) begin
                errors++;
                $display("FAIL idle_data_zero: data=%h required 0", resp_addr_data_o);
            end
        end
    end

    task automatic do_reset(input int hold);
        @(negedge clk_i);
        #2;
        aresetn_i = 1'b0;
        exp_q.delete();
        in_resp = 0;
        expect_idle = 0;
        model_clear();
        #1 check_reset_outputs("reset_async");
        repeat (hold) @(negedge clk_i);
        check_reset_outputs("reset_hold");
        #2 aresetn_i = 1'b1;
    endtask

    initial begin
        #200000;
        checks++; errors++;
        $display("FAIL watchdog: simulation time limit reached");
        finish_run();
    end

    initial begin
        logic [63:0] va, pa;
        logic [47:0] len;
        int r;
        model_clear();
        repeat (3) @(negedge clk_i);
        check_reset_outputs("reset_state");
        #2 aresetn_i = 1'b1;

        // Single entry at index 0
        cfg(0, 1, 64'h1000, 64'h8000_0000, 48'h2000, 4'h3);
        lookup(64'h1800);

        // Same entry moved to index 5: upper edge hit and just-past-end miss
        cfg(0, 0, '0, '0, '0, '0);
        cfg(5, 1, 64'h1000, 64'h8000_0000, 48'h2000, 4'h3);
        lookup(64'h2FFF);
        lookup(64'h3000);

        // Overlap: lowest index wins
        cfg(2, 1, 64'h0800, 64'h1_0000_0000, 48'h1000, 4'h5);
        cfg(4, 1, 64'h1000, 64'h2_0000_0000, 48'h0800, 4'h9);
        lookup(64'h1000);

        // Backpressure held for 10 cycles
        stall_left = 10;
        lookup(64'h1004);

        // Zero-length entry and paddr wrap
        cfg(1, 1, 64'h5000, 64'hFFFF_FFFF_FFFF_FF00, 48'h0, 4'h1);
        lookup(64'h5000);
        cfg(1, 1, 64'h5000, 64'hFFFF_FFFF_FFFF_FF00, 48'h400, 4'h1);
        lookup(64'h5200);

        // Randomized traffic
        for (int it = 0; it < 80; it++) begin
            r = $urandom_range(0, 9);
            va  = 64'($urandom_range(0, 15)) << 12;
            pa  = {$urandom, $urandom};
            len = ($urandom_range(0, 7) == 0) ? 48'h0 : 48'($urandom_range(1, 24'h3000));
            if (r < 4) begin
                cfg($urandom_range(0, NE - 1), $urandom_range(0, 3) != 0, va, pa, len, 4'($urandom));
            end else if (r < 9) begin
                if ($urandom_range(0, 7) == 0) lookup({$urandom, $urandom});
                else lookup(64'($urandom_range(0, 32'h14000)));
            end else begin
                cfg_and_lookup(1, $urandom_range(0, NE - 1), 1, va, pa, len, 4'($urandom),
                               1, va + 64'($urandom_range(0, 32'h1000)));
            end
        end

        // Same-cycle write and lookup, then reset during a search
        do_reset(2);
        cfg_and_lookup(1, 0, 1, 64'h1000, 64'h8000_0000, 48'h2000, 4'h3, 1, 64'h1800);
        lookup(64'h9000);
        repeat (4) @(negedge clk_i);
        do_reset(3);
        repeat (NE + 4) @(negedge clk_i);
        check_reset_outputs("after_reset_no_resp");
        lookup(64'h1800);

        wait_idle();
        repeat (2) @(negedge clk_i);
        finish_run();
    end

endmodule
